dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request acceptance to response valid; legal range 1..15.
REQ-003 Parameter DEPTH_WORDS, default 4096, SHALL set the number of 32-bit storage words.
REQ-004 Port clk, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the synchronous active-low reset.
REQ-006 Port req_valid, input, 1, SHALL indicate the processor presents a request.
REQ-007 Port req_ready, output, 1, SHALL indicate the responder can accept a request this cycle.
REQ-008 Port req_write, input, 1, SHALL select write (1) or read (0).
REQ-009 Port req_addr, input, 14, SHALL be the byte address.
REQ-010 Port req_wdata, input, 32, SHALL be the write data.
REQ-011 Port req_be, input, 4, SHALL be the byte enables for writes; bit i enables bits [8i+7:8i].
REQ-012 Port resp_valid, output, 1, SHALL indicate a response is presented.
REQ-013 Port resp_ready, input, 1, SHALL indicate the processor accepts the response.
REQ-014 Port resp_rdata, output, 32, SHALL be the read data; 0 for writes and errors.
REQ-015 Port resp_err, output, 1, SHALL flag a misaligned or out-of-range request.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL occur on an edge where req_valid and req_ready are both 1; write, addr, wdata and be SHALL be latched at that edge.
REQ-019 On acceptance the FSM SHALL go to WAIT with a 4-bit counter loaded with LATENCY-1; when LATENCY=1 it SHALL go directly to RESP.
REQ-020 In WAIT the counter SHALL decrement each cycle; the FSM SHALL enter RESP on the edge where the counter is 1.
REQ-021 resp_valid SHALL be 1 in RESP only, exactly LATENCY cycles after the acceptance edge.
REQ-022 A request SHALL be in error when latched addr[1:0] != 0 or addr[13:2] >= DEPTH_WORDS.
REQ-023 A non-error write SHALL update only the enabled bytes of word addr[13:2] on the edge entering RESP.
REQ-024 An error write SHALL not modify storage.
REQ-025 A non-error read SHALL register word addr[13:2] into resp_rdata on the edge entering RESP.
REQ-026 resp_rdata and resp_err SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-027 In RESP with resp_ready=1, the FSM SHALL return to IDLE next edge; resp_valid, resp_rdata and resp_err SHALL clear.
REQ-028 req_valid SHALL be ignored in WAIT and RESP, with no acceptance and no queuing; at most one request SHALL be outstanding.
REQ-029 A request asserted in the same cycle that RESP completes SHALL not be accepted until the following IDLE cycle.
REQ-030 Storage contents SHALL persist across requests; read-after-write to the same word SHALL return the written data.

Reset
REQ-031 With rst=0 at an edge, the FSM SHALL go to IDLE, the counter to 0, and resp_valid, resp_rdata, resp_err, the latched request registers to 0; req_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-032 Reset asserted in WAIT SHALL abort the request; a pending write SHALL not be committed.
REQ-033 Storage contents SHALL not be cleared by reset.

Verification
REQ-034 Reset, then write 0xDEADBEEF, be=4'hF to addr 0x0010 -> resp_valid at acceptance+2, resp_err=0; then read 0x0010 -> resp_rdata=0xDEADBEEF at acceptance+2.
REQ-035 Write 0x000000AA, be=4'b0001 to 0x0010 over 0xDEADBEEF -> a subsequent read returns 0xDEADBEAA.
REQ-036 Read addr 0x0013 -> resp_err=1, resp_rdata=0; write 0x0012 -> resp_err=1 and storage is unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP while req_valid=1 -> response stable, req_ready=0, no second acceptance; resp_ready=1 -> IDLE next cycle.
REQ-038 Assert rst=0 in WAIT of a write to 0x0020 holding 0x11111111 -> outputs cleared, req_ready=1 after release, and reading 0x0020 returns 0x11111111.
REQ-039 With LATENCY=1 and back-to-back requests -> resp_valid exactly 1 cycle after each acceptance, with one accepted request per 2 cycles at minimum.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder: one outstanding request, fixed LATENCY to response,
// byte-enabled writes, and an error flag for misaligned or out-of-range accesses.
module dmem_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          Direct  = (LATENCY == 1);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [13:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_write;
  logic [13:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd;
  logic          w_enter_resp;
  logic          w_commit;

  // With LATENCY=1 the response is formed on the acceptance edge, so use the live request.
  assign w_write = Direct ? req_write : r_write;
  assign w_addr  = Direct ? req_addr  : r_addr;
  assign w_wdata = Direct ? req_wdata : r_wdata;
  assign w_be    = Direct ? req_be    : r_be;

  assign w_err = (w_addr[1:0] != 2'b00) || (32'(w_addr[13:2]) >= DEPTH_WORDS);
  assign w_idx = w_addr[AW+1:2];
  assign w_rd  = r_mem[w_idx];

  assign w_enter_resp = ((r_state == StWait) && (r_cnt == 4'd1)) ||
                        (Direct && (r_state == StIdle) && req_valid);
  assign w_commit     = rst && w_enter_resp && w_write && !w_err;

  assign req_ready  = (r_state == StIdle);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 14'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (Direct) begin
              r_state <= StResp;
            end else begin
              r_state <= StWait;
              r_cnt   <= CntLoad;
            end
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            r_state      <= StIdle;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (!w_write && !w_err) ? w_rd : 32'd0;
      end
    end
  end

endmodule
